mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the ARM-subset processor; replaces the single-cycle decoder when the datapath shares one memory and one ALU across instruction phases. Holds a Moore main FSM, the ALU decoder (extended with flag-write gating), an NZCV flags register and conditional-execution logic. Drives every datapath select and enable from `Op`/`Funct`/`Rd`/`Cond` and the ALU flags.

## Interface
- `ALUCTRL_W`, default 3: width of `ALUControl`.
- `RESET_PC_WAIT`, default 0: idle cycles held in FETCH after reset release, range 0–3.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `Cond` in 4: instruction bits 31:28.
- `Op` in 2: bits 27:26.
- `Funct` in 6: bits 25:20.
- `Rd` in 4: bits 15:12.
- `ALUFlags` in 4: {N,Z,C,V} from ALU, current cycle.
- `PCWrite`, `AdrSrc`, `MemWrite`, `IRWrite`, `RegWrite` out 1: datapath enables/selects.
- `ResultSrc`, `ALUSrcA`, `ALUSrcB`, `ImmSrc`, `RegSrc` out 2: datapath selects.
- `ALUControl` out `ALUCTRL_W`: ADD=0, SUB=1, AND=2, ORR=3, EOR=6.
- `Shift` out 1: select shifter result (LSL).
- `Flags` out 4: registered {N,Z,C,V}.
- `IllegalInstr` out 1: one-cycle pulse on undecodable instruction.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH→DECODE always (after `RESET_PC_WAIT` cycles following reset only). DECODE: Op=01→MEMADR; Op=00 & Funct[5]→EXECI; Op=00 & !Funct[5]→EXECR; Op=10→BRANCH; Op=11 or unknown DP Funct[4:1]→FETCH with `IllegalInstr`=1.
- MEMADR: Funct[0]→MEMRD else MEMWR. MEMRD→MEMWB→FETCH. MEMWR→FETCH. EXECR/EXECI→ALUWB→FETCH. BRANCH→FETCH.
- DP decode Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, NoWrite), 1001 TEQ (EOR, NoWrite), 1101 LSL (Shift=1, ALUControl=ADD). Others illegal.
- FlagW[1] (N,Z) = Funct[0] in DP; FlagW[0] (C,V) = Funct[0] & (ADD|SUB). TEQ/CMP set flags regardless of NoWrite.
- CondEx: EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE per ARM; 1110 always; 1111 never.
- CondEx evaluated from `Flags` in DECODE and latched into `CondExR` on DECODE exit; all later gating uses `CondExR`.
- Flags update at end of EXECR/EXECI: N,Z when FlagW[1]&CondExR; C,V when FlagW[0]&CondExR.
- RegWrite=1 in ALUWB only if CondExR & !NoWrite; in MEMWB only if CondExR. MemWrite=1 in MEMWR only if CondExR.
- PCWrite=1 in FETCH; in BRANCH if CondExR; in ALUWB/MEMWB if Rd=1111 & write allowed (PC-destination write).
- Per-state selects: FETCH AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10; DECODE ALUSrcA=01, ALUSrcB=10, ResultSrc=10; MEMADR/EXECI ALUSrcB=01; EXECR ALUSrcB=00; MEMRD/MEMWR AdrSrc=1; MEMWB ResultSrc=01; ALUWB ResultSrc=00; BRANCH ALUSrcB=01, ResultSrc=10. ImmSrc/RegSrc: DP-imm 00/00, mem 01/10 (STR) or 01/00 (LDR), branch 10/01.
- ALUControl=ADD outside EXECR/EXECI.

## Timing
- Reset (async, `reset`=0): state=FETCH, Flags=0000, CondExR=0, all enables 0, selects 00, IllegalInstr=0. Enables stay 0 while reset asserted.
- Cycles per instruction: branch 3, DP 4, STR 4, LDR 5, illegal 2. Reset mid-instruction aborts; no pending write completes.
- Outputs are Moore (state + latched instruction fields); ALUControl/Shift combinational from Funct in EXEC states.
- Flags written in EXEC are visible to the next instruction's DECODE.

## Structure
- Package `mc_pkg`: state enum, ALUControl encodings, Cond encodings, select encodings.
- Sub-module `cond_check` (combinational Cond × Flags → CondEx); FSM, ALU decode and flags register in top.

## Test plan
- Reset release, `ADD R1,R2,#5` (Op=00,Funct=101000,Cond=1110): FETCH→DECODE→EXECI→ALUWB; RegWrite=1 in ALUWB only, Flags unchanged.
- `SUBS` with ALUFlags=0100 then `ADDEQ R0`: Flags=0100 after EXEC; ADDEQ RegWrite=1; repeat with Flags=0000 → RegWrite stays 0 across all 4 cycles.
- `CMP` (Funct=010101): RegWrite=0, Flags=ALUFlags; `TEQ` sets N,Z only, C,V retained.
- LDR 5 cycles with MEMWB RegWrite=1; STR Cond=0000, Z=0: MemWrite=0 in MEMWR.
- Branch Cond=1110: PCWrite=1 in BRANCH; Cond=1111: PCWrite=0; Op=11: IllegalInstr one-cycle pulse, back in FETCH after 2 cycles.
- Assert `reset` in ALUWB: all outputs 0 immediately, FETCH on release, Flags=0000.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit.
// State, ALU op, DP command, condition and datapath select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd6;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_TEQ = 4'b1001;
  localparam logic [3:0] CMD_LSL = 4'b1101;

  localparam logic [3:0] C_EQ = 4'b0000;
  localparam logic [3:0] C_NE = 4'b0001;
  localparam logic [3:0] C_CS = 4'b0010;
  localparam logic [3:0] C_CC = 4'b0011;
  localparam logic [3:0] C_MI = 4'b0100;
  localparam logic [3:0] C_PL = 4'b0101;
  localparam logic [3:0] C_VS = 4'b0110;
  localparam logic [3:0] C_VC = 4'b0111;
  localparam logic [3:0] C_HI = 4'b1000;
  localparam logic [3:0] C_LS = 4'b1001;
  localparam logic [3:0] C_GE = 4'b1010;
  localparam logic [3:0] C_LT = 4'b1011;
  localparam logic [3:0] C_GT = 4'b1100;
  localparam logic [3:0] C_LE = 4'b1101;
  localparam logic [3:0] C_AL = 4'b1110;

  localparam logic [1:0] SRCA_REG  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_OUT   = 2'b00;
  localparam logic [1:0] RES_DATA  = 2'b01;
  localparam logic [1:0] RES_ALU   = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

endpackage

// File: rtl/mc_controller_cond.sv
// Condition-code evaluation for conditional execution.
// Purely combinational: Cond x {N,Z,C,V} -> execute/skip.
module cond_check
  import mc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  // ARM condition table; 1111 never executes
  always_comb begin
    condex = 1'b0;
    unique case (cond)
      C_EQ: condex = z;
      C_NE: condex = !z;
      C_CS: condex = c;
      C_CC: condex = !c;
      C_MI: condex = n;
      C_PL: condex = !n;
      C_VS: condex = v;
      C_VC: condex = !v;
      C_HI: condex = c && !z;
      C_LS: condex = !c || z;
      C_GE: condex = n == v;
      C_LT: condex = n != v;
      C_GT: condex = !z && (n == v);
      C_LE: condex = z || (n != v);
      C_AL: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: Moore main FSM, ALU decoder,
// NZCV flags register and conditional-execution gating.
module mc_controller
  import mc_pkg::*;
#(
  parameter int ALUCTRL_W     = 3,
  parameter int RESET_PC_WAIT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Shift,
  output logic [3:0]           Flags,
  output logic                 IllegalInstr
);

  localparam logic [1:0] WAIT_INIT = 2'(RESET_PC_WAIT);

  state_t     state, state_nx;
  logic [1:0] wait_q;
  logic       condex, condexr;
  logic [3:0] flags_q;

  logic       dp_ok, nowrite, is_lsl, cv_ok;
  logic [2:0] alu_op;
  logic [1:0] flagw;
  logic       illegal, pc_dst;
  logic [1:0] imm_sel, reg_sel;

  cond_check u_cond (
    .cond   (Cond),
    .flags  (flags_q),
    .condex (condex)
  );

  // Data-processing command decode from Funct[4:1]
  always_comb begin
    dp_ok   = 1'b1;
    nowrite = 1'b0;
    is_lsl  = 1'b0;
    cv_ok   = 1'b0;
    alu_op  = ALU_ADD;
    unique case (Funct[4:1])
      CMD_ADD: cv_ok = 1'b1;
      CMD_SUB: begin
        alu_op = ALU_SUB;
        cv_ok  = 1'b1;
      end
      CMD_AND: alu_op = ALU_AND;
      CMD_ORR: alu_op = ALU_ORR;
      CMD_CMP: begin
        alu_op  = ALU_SUB;
        nowrite = 1'b1;
        cv_ok   = 1'b1;
      end
      CMD_TEQ: begin
        alu_op  = ALU_EOR;
        nowrite = 1'b1;
      end
      CMD_LSL: is_lsl = 1'b1;
      default: dp_ok = 1'b0;
    endcase
  end

  assign flagw   = {Funct[0], Funct[0] & cv_ok};
  assign illegal = (Op == 2'b11) || (Op == 2'b00 && !dp_ok);
  assign pc_dst  = (Rd == 4'b1111);

  // Immediate/register-port selects by instruction class
  always_comb begin
    imm_sel = IMM_DP;
    reg_sel = 2'b00;
    unique case (Op)
      2'b01: begin
        imm_sel = IMM_MEM;
        reg_sel = Funct[0] ? 2'b00 : 2'b10;
      end
      2'b10: begin
        imm_sel = IMM_BR;
        reg_sel = 2'b01;
      end
      default: ;
    endcase
  end

  // State, post-reset wait, latched condition and flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      wait_q  <= WAIT_INIT;
      condexr <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && wait_q != 2'd0)
        wait_q <= wait_q - 2'd1;
      if (state == S_DECODE)
        condexr <= condex;
      if ((state == S_EXECR || state == S_EXECI) && condexr) begin
        if (flagw[1]) flags_q[3:2] <= ALUFlags[3:2];
        if (flagw[0]) flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH:
        if (wait_q == 2'd0) state_nx = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (Op == 2'b01): state_nx = S_MEMADR;
          (Op == 2'b10): state_nx = S_BRANCH;
          (Op == 2'b00 && dp_ok):
            state_nx = Funct[5] ? S_EXECI : S_EXECR;
          default: state_nx = S_FETCH;
        endcase
      end
      S_MEMADR:
        state_nx = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nx = S_MEMWB;
      S_MEMWB:  state_nx = S_FETCH;
      S_MEMWR:  state_nx = S_FETCH;
      S_EXECR:  state_nx = S_ALUWB;
      S_EXECI:  state_nx = S_ALUWB;
      S_ALUWB:  state_nx = S_FETCH;
      S_BRANCH: state_nx = S_FETCH;
      default:  state_nx = S_FETCH;
    endcase
  end

  // Moore outputs, forced low while reset is held
  always_comb begin
    PCWrite      = 1'b0;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = RES_OUT;
    ALUSrcA      = SRCA_REG;
    ALUSrcB      = SRCB_REG;
    ImmSrc       = 2'b00;
    RegSrc       = 2'b00;
    ALUControl   = ALUCTRL_W'(ALU_ADD);
    Shift        = 1'b0;
    IllegalInstr = 1'b0;
    if (reset) begin
      unique case (state)
        S_FETCH: begin
          if (wait_q == 2'd0) begin
            PCWrite = 1'b1;
            IRWrite = 1'b1;
          end
          ALUSrcA   = SRCA_PC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
        end
        S_DECODE: begin
          ALUSrcA      = SRCA_PC;
          ALUSrcB      = SRCB_FOUR;
          ResultSrc    = RES_ALU;
          IllegalInstr = illegal;
        end
        S_MEMADR: ALUSrcB = SRCB_IMM;
        S_MEMRD:  AdrSrc = 1'b1;
        S_MEMWR: begin
          AdrSrc   = 1'b1;
          MemWrite = condexr;
        end
        S_MEMWB: begin
          ResultSrc = RES_DATA;
          RegWrite  = condexr;
          PCWrite   = condexr && pc_dst;
        end
        S_EXECR: begin
          ALUSrcB    = SRCB_REG;
          ALUControl = ALUCTRL_W'(alu_op);
          Shift      = is_lsl;
        end
        S_EXECI: begin
          ALUSrcB    = SRCB_IMM;
          ALUControl = ALUCTRL_W'(alu_op);
          Shift      = is_lsl;
        end
        S_ALUWB: begin
          ResultSrc = RES_OUT;
          RegWrite  = condexr && !nowrite;
          PCWrite   = condexr && !nowrite && pc_dst;
        end
        S_BRANCH: begin
          ALUSrcB   = SRCB_IMM;
          ResultSrc = RES_ALU;
          PCWrite   = condexr;
        end
        default: ;
      endcase
      if (state != S_FETCH) begin
        ImmSrc = imm_sel;
        RegSrc = reg_sel;
      end
    end
  end

  assign Flags = flags_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed cases
// plus random instruction stream against a phase-level model.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic       Shift, IllegalInstr;
  logic [3:0] Flags;

  int n_run  = 0;
  int n_fail = 0;
  logic [3:0] mflags = 4'b0000;

  mc_controller dut (
    .clk          (clk),
    .reset        (reset),
    .Cond         (Cond),
    .Op           (Op),
    .Funct        (Funct),
    .Rd           (Rd),
    .ALUFlags     (ALUFlags),
    .PCWrite      (PCWrite),
    .AdrSrc       (AdrSrc),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .RegWrite     (RegWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ImmSrc       (ImmSrc),
    .RegSrc       (RegSrc),
    .ALUControl   (ALUControl),
    .Shift        (Shift),
    .Flags        (Flags),
    .IllegalInstr (IllegalInstr)
  );

  always #5 clk = ~clk;

  wire [27:0] all_out = {PCWrite, AdrSrc, MemWrite, IRWrite,
    RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
    ALUControl, Shift, IllegalInstr, Flags};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] c,
                                   input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One instruction from FETCH to the next FETCH, checking each cycle
  task automatic run(input logic [3:0] c, input logic [1:0] op,
                     input logic [5:0] fn, input logic [3:0] rd,
                     input logic [3:0] af, input int abort_at);
    logic legal, nw, sh, cvw, ill, is_dp, ldr, str, ce;
    logic [2:0] aop;
    logic [5:0] en;
    logic [3:0] isr;
    int n;
    legal = 1; nw = 0; sh = 0; cvw = 0; aop = 3'd0;
    case (fn[4:1])
      4'b0100: cvw = 1;
      4'b0010: begin aop = 3'd1; cvw = 1; end
      4'b0000: aop = 3'd2;
      4'b1100: aop = 3'd3;
      4'b1010: begin aop = 3'd1; cvw = 1; nw = 1; end
      4'b1001: begin aop = 3'd6; nw = 1; end
      4'b1101: sh = 1;
      default: legal = 0;
    endcase
    ill   = (op == 2'd3) || (op == 2'd0 && !legal);
    is_dp = (op == 2'd0) && legal;
    ldr   = (op == 2'd1) && fn[0];
    str   = (op == 2'd1) && !fn[0];
    ce    = cond_ok(c, mflags);
    n     = ill ? 2 : (op == 2'd2) ? 3 : ldr ? 5 : 4;
    isr   = (op == 2'd1) ? {2'b01, fn[0] ? 2'b00 : 2'b10}
          : (op == 2'd2) ? 4'b1001 : 4'b0000;
    Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
    #1;
    for (int p = 0; p < n; p++) begin
      en = 6'b0;
      if (p == 0) en = 6'b110000;
      else if (p == 1 && ill) en = 6'b000001;
      else if (op == 2'd2 && p == 2) en[5] = ce;
      else if (is_dp && p == 3) begin
        en[3] = ce && !nw;
        en[5] = ce && !nw && rd == 4'hF;
      end
      else if (ldr && p == 3) en[1] = 1;
      else if (ldr && p == 4) begin
        en[3] = ce;
        en[5] = ce && rd == 4'hF;
      end
      else if (str && p == 3) begin
        en[1] = 1;
        en[2] = ce;
      end
      check($sformatf("en op%0d p%0d", op, p),
        {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, IllegalInstr},
        en);
      check($sformatf("alu p%0d", p), {ALUControl, Shift},
        (is_dp && p == 2) ? {aop, sh} : 4'b0);
      check($sformatf("flags p%0d", p), Flags, mflags);
      if (p == 0)
        check("fetch_sel", {ALUSrcA, ALUSrcB, ResultSrc}, 6'b011010);
      if (p == 1)
        check("imm_reg", {ImmSrc, RegSrc}, isr);
      if (p == abort_at) begin
        reset = 1'b0;
        #1;
        check("abort_outs", all_out, 28'd0);
        mflags = 4'b0000;
        #2;
        reset = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
      if (is_dp && p == 2 && ce) begin
        if (fn[0]) mflags[3:2] = af[3:2];
        if (fn[0] && cvw) mflags[1:0] = af[1:0];
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rc, rrd, raf;
    logic [1:0] rop;
    logic [5:0] rfn;
    reset = 1'b0;
    Cond = 4'hE; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", all_out, 28'd0);
    reset = 1'b1;

    run(4'hE, 2'd0, 6'b101000, 4'd1, 4'b1111, -1);
    run(4'hE, 2'd0, 6'b000101, 4'd2, 4'b0100, -1);
    check("subs_flags", Flags, 4'b0100);
    run(4'h0, 2'd0, 6'b101000, 4'd0, 4'b0000, -1);
    run(4'hE, 2'd0, 6'b000101, 4'd2, 4'b0000, -1);
    run(4'h0, 2'd0, 6'b101000, 4'd0, 4'b0000, -1);
    run(4'hE, 2'd0, 6'b010101, 4'd0, 4'b1011, -1);
    check("cmp_flags", Flags, 4'b1011);
    run(4'hE, 2'd0, 6'b010011, 4'd0, 4'b0100, -1);
    check("teq_flags", Flags, 4'b0111);
    run(4'hE, 2'd1, 6'b011001, 4'd3, 4'b0000, -1);
    run(4'hE, 2'd0, 6'b010101, 4'd0, 4'b0000, -1);
    run(4'h0, 2'd1, 6'b011000, 4'd3, 4'b0000, -1);
    run(4'hE, 2'd2, 6'b000000, 4'd0, 4'b0000, -1);
    run(4'hF, 2'd2, 6'b000000, 4'd0, 4'b0000, -1);
    run(4'hE, 2'd3, 6'b000000, 4'd0, 4'b0000, -1);
    run(4'hE, 2'd0, 6'b011110, 4'd0, 4'b0000, -1);
    run(4'hE, 2'd0, 6'b101000, 4'hF, 4'b0000, -1);
    run(4'hE, 2'd1, 6'b011001, 4'hF, 4'b0000, -1);
    run(4'hE, 2'd0, 6'b101001, 4'd1, 4'b1010, -1);
    run(4'hE, 2'd0, 6'b101000, 4'd1, 4'b0000, 3);
    check("abort_flags", Flags, 4'b0000);

    for (int i = 0; i < 400; i++) begin
      rop = 2'($urandom_range(0, 3));
      rfn = 6'($urandom);
      rc  = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom);
      rrd = 4'($urandom);
      raf = 4'($urandom);
      if (rop == 2'd0) begin
        if (rfn[4:1] == 4'b1101) rfn[0] = 1'b0;
        if (rfn[4:1] == 4'b1010 || rfn[4:1] == 4'b1001)
          rfn[0] = 1'b1;
      end
      run(rc, rop, rfn, rrd, raf,
          ($urandom_range(0, 49) == 0) ? 2 : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
